// File: rtl/prog_run_ctrl.sv
// Run controller for the single-program core: loads a 16-bit operand into
// core data memory, starts the core, waits for done under a watchdog, reads
// the 16-bit result back and presents it on a valid/ready response port.
// Also owns the data-memory port mux between the controller and the core.
module prog_run_ctrl #(
  parameter int unsigned OP_ADDR  = 4,
  parameter int unsigned RES_ADDR = 6,
  parameter int unsigned TIMEOUT  = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [15:0] req_operand,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [15:0] resp_data,
  output logic        resp_timeout,
  output logic        core_start,
  input  logic        core_done,
  input  logic        core_mem_we,
  input  logic [7:0]  core_mem_addr,
  input  logic [7:0]  core_mem_wdata,
  output logic        mem_we,
  output logic [7:0]  mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata
);

  localparam logic [7:0]  OP_LO    = 8'(OP_ADDR);
  localparam logic [7:0]  OP_HI    = 8'(OP_ADDR + 1);
  localparam logic [7:0]  RES_LO   = 8'(RES_ADDR);
  localparam logic [7:0]  RES_HI   = 8'(RES_ADDR + 1);
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    IDLE, WR_LO, WR_HI, START, RUN, RD_LO, RD_HI, CAP, RESP
  } state_t;

  state_t      state;
  logic [7:0]  op_hi;
  logic [15:0] cnt;
  logic [15:0] resp_data_r;
  logic        tmo_r;
  logic        rdy_r;
  logic        vld_r;
  logic        start_r;
  logic        we_r;
  logic [7:0]  addr_r;
  logic [7:0]  wdata_r;
  logic        core_owns;

  // Sequencer: state plus registered controller-side outputs, loaded on the
  // transition into the state that uses them.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      resp_data_r <= 16'h0000;
      tmo_r       <= 1'b0;
      rdy_r       <= 1'b1;
      vld_r       <= 1'b0;
      start_r     <= 1'b0;
      we_r        <= 1'b0;
      addr_r      <= 8'h00;
      wdata_r     <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && rdy_r) begin
            op_hi   <= req_operand[15:8];
            rdy_r   <= 1'b0;
            we_r    <= 1'b1;
            addr_r  <= OP_LO;
            wdata_r <= req_operand[7:0];
            state   <= WR_LO;
          end
        end
        WR_LO: begin
          addr_r  <= OP_HI;
          wdata_r <= op_hi;
          state   <= WR_HI;
        end
        WR_HI: begin
          we_r    <= 1'b0;
          addr_r  <= 8'h00;
          wdata_r <= 8'h00;
          start_r <= 1'b1;
          state   <= START;
        end
        START: begin
          start_r <= 1'b0;
          cnt     <= 16'h0000;
          state   <= RUN;
        end
        RUN: begin
          cnt <= cnt + 16'd1;
          // A done seen while the counter is still 0 may be left over from
          // the previous program run, so it is not trusted.
          if (core_done && (cnt != 16'h0000)) begin
            addr_r <= RES_LO;
            state  <= RD_LO;
          end else if (cnt == CNT_LAST) begin
            tmo_r       <= 1'b1;
            resp_data_r <= 16'h0000;
            vld_r       <= 1'b1;
            state       <= RESP;
          end
        end
        RD_LO: begin
          addr_r <= RES_HI;
          state  <= RD_HI;
        end
        RD_HI: begin
          resp_data_r[7:0] <= mem_rdata;
          addr_r           <= 8'h00;
          state            <= CAP;
        end
        CAP: begin
          resp_data_r[15:8] <= mem_rdata;
          tmo_r             <= 1'b0;
          vld_r             <= 1'b1;
          state             <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            vld_r <= 1'b0;
            rdy_r <= 1'b1;
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // The core owns the memory port only while it is running; outside that
  // window its writes are dropped. Reset forces the idle output values.
  assign core_owns    = (state == START) || (state == RUN);
  assign req_ready    = !reset || rdy_r;
  assign resp_valid   = reset && vld_r;
  assign core_start   = reset && start_r;
  assign mem_we       = reset && (core_owns ? core_mem_we : we_r);
  assign mem_addr     = !reset ? 8'h00 : (core_owns ? core_mem_addr : addr_r);
  assign mem_wdata    = !reset ? 8'h00 : (core_owns ? core_mem_wdata : wdata_r);
  assign resp_data    = resp_data_r;
  assign resp_timeout = tmo_r;

endmodule

// File: tb/tb_prog_run_ctrl.sv
// Directed bench for prog_run_ctrl: two instances (default watchdog and a
// 16-cycle watchdog), each with a registered-read data memory, driven by a
// linear step sequence; expected responses go through a scoreboard queue.
module tb_prog_run_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  // instance A (TIMEOUT=4096)
  logic        req_valid, req_ready, resp_valid, resp_ready, resp_timeout;
  logic [15:0] req_operand, resp_data;
  logic        core_start, core_done, core_mem_we, mem_we;
  logic [7:0]  core_mem_addr, core_mem_wdata, mem_addr, mem_wdata, mem_rdata;
  // instance B (TIMEOUT=16)
  logic        b_req_valid, b_req_ready, b_resp_valid, b_resp_ready, b_resp_timeout;
  logic [15:0] b_req_operand, b_resp_data;
  logic        b_core_start, b_core_done, b_core_mem_we, b_mem_we;
  logic [7:0]  b_core_mem_addr, b_core_mem_wdata, b_mem_addr, b_mem_wdata, b_mem_rdata;

  prog_run_ctrl u_dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_operand(req_operand),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_timeout(resp_timeout), .core_start(core_start), .core_done(core_done),
    .core_mem_we(core_mem_we), .core_mem_addr(core_mem_addr),
    .core_mem_wdata(core_mem_wdata), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  prog_run_ctrl #(.TIMEOUT(16)) u_dut16 (
    .clk(clk), .reset(reset),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_operand(b_req_operand),
    .resp_valid(b_resp_valid), .resp_ready(b_resp_ready), .resp_data(b_resp_data),
    .resp_timeout(b_resp_timeout), .core_start(b_core_start), .core_done(b_core_done),
    .core_mem_we(b_core_mem_we), .core_mem_addr(b_core_mem_addr),
    .core_mem_wdata(b_core_mem_wdata), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
  );

  logic [7:0] mem_a [256];
  logic [7:0] mem_b [256];

  always @(posedge clk) begin
    if (mem_we) mem_a[mem_addr] <= mem_wdata;
    mem_rdata <= mem_a[mem_addr];
  end

  always @(posedge clk) begin
    if (b_mem_we) mem_b[b_mem_addr] <= b_mem_wdata;
    b_mem_rdata <= mem_b[b_mem_addr];
  end

  typedef struct packed {
    logic        tmo;
    logic [15:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send_a(input logic [15:0] op, input logic [15:0] exp_data);
    int n = 0;
    while (!req_ready && n < 50) begin cyc(); n++; end
    chk("req_ready_before_send", req_ready, 1);
    req_valid   = 1'b1;
    req_operand = op;
    sb.push_back({1'b0, exp_data});
    cyc();
    req_valid = 1'b0;
    chk("req_taken", req_ready, 0);
  endtask

  // Model core for instance A: result bytes written at delay-2/delay-1,
  // done pulsed 'delay' cycles after the start cycle.
  task automatic core_a(input logic [15:0] op, input logic [15:0] res,
                        input int delay, input bit stale);
    int n = 0;
    while (!core_start && n < 50) begin cyc(); n++; end
    chk("start_seen", core_start, 1);
    chk("op_lo_in_mem", mem_a[4], op[7:0]);
    chk("op_hi_in_mem", mem_a[5], op[15:8]);
    cyc();
    chk("start_one_cycle", core_start, 0);
    if (stale) core_done = 1'b0;
    for (int t = 1; t < delay; t++) begin
      if (t == delay - 2) begin
        core_mem_we = 1'b1; core_mem_addr = 8'd6; core_mem_wdata = res[7:0];
      end else if (t == delay - 1) begin
        core_mem_addr = 8'd7; core_mem_wdata = res[15:8];
      end
      if (stale) chk("stale_done_ignored", resp_valid, 0);
      cyc();
    end
    core_mem_we = 1'b0;
    chk("core_wr_lo_reaches_mem", mem_a[6], res[7:0]);
    chk("core_wr_hi_reaches_mem", mem_a[7], res[15:8]);
    core_done = 1'b1;
    cyc();
    core_done = 1'b0;
    repeat (3) begin
      chk("resp_not_early", resp_valid, 0);
      cyc();
    end
    chk("resp_3_edges_after_done", resp_valid, 1);
  endtask

  task automatic get_resp(input bit is_b, input string tag);
    int   n = 0;
    exp_t e;
    while (!(is_b ? b_resp_valid : resp_valid) && n < 200) begin cyc(); n++; end
    chk({tag, "_valid"}, is_b ? b_resp_valid : resp_valid, 1);
    chk({tag, "_sb_nonempty"}, (sb.size() != 0), 1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, "_data"}, is_b ? b_resp_data : resp_data, e.data);
      chk({tag, "_timeout"}, is_b ? b_resp_timeout : resp_timeout, e.tmo);
    end
    if (is_b) b_resp_ready = 1'b1; else resp_ready = 1'b1;
    cyc();
    b_resp_ready = 1'b0;
    resp_ready   = 1'b0;
    chk({tag, "_valid_drop"}, is_b ? b_resp_valid : resp_valid, 0);
    chk({tag, "_req_ready_back"}, is_b ? b_req_ready : req_ready, 1);
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout observed=running required=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int n;
    int seen;
    reset = 1'b0;
    req_valid = 1'b0; req_operand = 16'h0; resp_ready = 1'b0;
    core_done = 1'b0; core_mem_we = 1'b0; core_mem_addr = 8'h0; core_mem_wdata = 8'h0;
    b_req_valid = 1'b0; b_req_operand = 16'h0; b_resp_ready = 1'b0;
    b_core_done = 1'b0; b_core_mem_we = 1'b0; b_core_mem_addr = 8'h0; b_core_mem_wdata = 8'h0;
    repeat (2) cyc();
    chk("rst_req_ready", req_ready, 1);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_core_start", core_start, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_resp_data", resp_data, 0);
    chk("rst_resp_timeout", resp_timeout, 0);
    chk("rst_b_req_ready", b_req_ready, 1);
    reset = 1'b1;
    cyc();

    // operand 1.0, core returns 1 after 20 cycles
    send_a(16'h3C00, 16'h0001);
    core_a(16'h3C00, 16'h0001, 20, 1'b0);
    get_resp(1'b0, "t1");

    // operand 0xFB80, core returns 0x8000
    send_a(16'hFB80, 16'h8000);
    core_a(16'hFB80, 16'h8000, 10, 1'b0);
    get_resp(1'b0, "t2");

    // core write while idle must be dropped
    core_mem_we = 1'b1; core_mem_addr = 8'd6; core_mem_wdata = 8'hAA;
    #1;
    chk("idle_mem_we_blocked", mem_we, 0);
    cyc();
    core_mem_we = 1'b0;
    chk("idle_core_wr_dropped", mem_a[6], 8'h00);

    // response back-pressure with a pending request
    send_a(16'h4000, 16'h1234);
    core_a(16'h4000, 16'h1234, 6, 1'b0);
    req_valid = 1'b1; req_operand = 16'h4000;
    for (int i = 0; i < 10; i++) begin
      chk("hold_resp_valid", resp_valid, 1);
      chk("hold_resp_data", resp_data, 16'h1234);
      chk("hold_req_ready", req_ready, 0);
      cyc();
    end
    get_resp(1'b0, "t3");
    sb.push_back({1'b0, 16'h5678});
    cyc();
    req_valid = 1'b0;
    chk("next_req_accepted", req_ready, 0);
    chk("next_req_wr_lo_we", mem_we, 1);
    chk("next_req_wr_lo_addr", mem_addr, 8'd4);
    core_a(16'h4000, 16'h5678, 8, 1'b0);
    get_resp(1'b0, "t3b");

    // stale done held entering START
    send_a(16'h1111, 16'h2222);
    core_done = 1'b1;
    core_a(16'h1111, 16'h2222, 6, 1'b1);
    get_resp(1'b0, "t4");

    // reset pulled during RUN aborts with no response
    send_a(16'h7777, 16'h0000);
    void'(sb.pop_back());
    n = 0;
    while (!core_start && n < 50) begin cyc(); n++; end
    chk("abort_start_seen", core_start, 1);
    repeat (2) cyc();
    reset = 1'b0;
    #1;
    chk("abort_in_rst_req_ready", req_ready, 1);
    chk("abort_in_rst_resp_valid", resp_valid, 0);
    cyc();
    reset = 1'b1;
    chk("abort_req_ready", req_ready, 1);
    chk("abort_resp_valid", resp_valid, 0);
    chk("abort_core_start", core_start, 0);
    chk("abort_mem_we", mem_we, 0);
    core_done = 1'b1;
    cyc();
    core_done = 1'b0;
    seen = 0;
    repeat (30) begin
      if (resp_valid) seen++;
      cyc();
    end
    chk("abort_no_response", seen, 0);
    send_a(16'h3C00, 16'h0001);
    core_a(16'h3C00, 16'h0001, 5, 1'b0);
    get_resp(1'b0, "t5");

    // watchdog on the 16-cycle instance, core never finishes
    b_req_valid = 1'b1; b_req_operand = 16'h3C00;
    sb.push_back({1'b1, 16'h0000});
    cyc();
    b_req_valid = 1'b0;
    n = 0;
    while (!b_core_start && n < 50) begin cyc(); n++; end
    chk("b_start_seen", b_core_start, 1);
    n = 0;
    while (!b_resp_valid && n < 40) begin cyc(); n++; end
    chk("b_tmo_edges_after_start", n, 17);
    get_resp(1'b1, "b_tmo");

    // following request on the same instance completes normally
    b_req_valid = 1'b1; b_req_operand = 16'h4000;
    sb.push_back({1'b0, 16'hBEEF});
    cyc();
    b_req_valid = 1'b0;
    n = 0;
    while (!b_core_start && n < 50) begin cyc(); n++; end
    chk("b2_start_seen", b_core_start, 1);
    repeat (2) cyc();
    b_core_mem_we = 1'b1; b_core_mem_addr = 8'd6; b_core_mem_wdata = 8'hEF;
    cyc();
    b_core_mem_addr = 8'd7; b_core_mem_wdata = 8'hBE;
    cyc();
    b_core_mem_we = 1'b0;
    b_core_done = 1'b1;
    cyc();
    b_core_done = 1'b0;
    get_resp(1'b1, "b_ok");

    chk("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
